// File: rtl/rsa_engine_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine between an encrypt
// and a decrypt requester, with a per-job cycle budget that aborts a stuck engine.
module rsa_engine_arbiter #(
    parameter int unsigned KEY_WIDTH = 64,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [KEY_WIDTH-1:0] req0_base,
    input  logic [KEY_WIDTH-1:0] req0_exp,
    input  logic [KEY_WIDTH-1:0] req0_mod,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [KEY_WIDTH-1:0] req1_base,
    input  logic [KEY_WIDTH-1:0] req1_exp,
    input  logic [KEY_WIDTH-1:0] req1_mod,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [KEY_WIDTH-1:0] rsp0_data,
    output logic                 rsp0_err,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [KEY_WIDTH-1:0] rsp1_data,
    output logic                 rsp1_err,
    output logic                 eng_start,
    output logic [KEY_WIDTH-1:0] eng_base,
    output logic [KEY_WIDTH-1:0] eng_exp,
    output logic [KEY_WIDTH-1:0] eng_mod,
    input  logic                 eng_done,
    input  logic [KEY_WIDTH-1:0] eng_result,
    output logic                 eng_abort,
    output logic                 busy,
    output logic                 owner
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic [KEY_WIDTH-1:0] base_q, base_d;
    logic [KEY_WIDTH-1:0] exp_q, exp_d;
    logic [KEY_WIDTH-1:0] mod_q, mod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic                 rsp0_valid_q, rsp0_valid_d;
    logic                 rsp1_valid_q, rsp1_valid_d;
    logic                 eng_start_q, eng_start_d;

    logic grant0_c;
    logic grant1_c;
    logic timeout_c;
    logic rsp_hs_c;

    // Grant decode: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant0_c   = req0_valid && (!req1_valid || last_grant_q);
        grant1_c   = req1_valid && (!req0_valid || !last_grant_q);
        timeout_c  = (cnt_q == CNT_LAST);
        rsp_hs_c   = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);
        req0_ready = rst_n && (state_q == S_IDLE) && grant0_c;
        req1_ready = rst_n && (state_q == S_IDLE) && grant1_c;
        // A done landing on the last budget cycle wins over the abort.
        eng_abort  = rst_n && (state_q == S_WAIT) && timeout_c && !eng_done;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        base_d       = base_q;
        exp_d        = exp_q;
        mod_d        = mod_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        eng_start_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_ready) begin
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    base_d       = req0_base;
                    exp_d        = req0_exp;
                    mod_d        = req0_mod;
                    eng_start_d  = 1'b1;
                    state_d      = S_ISSUE;
                end else if (req1_ready) begin
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    base_d       = req1_base;
                    exp_d        = req1_exp;
                    mod_d        = req1_mod;
                    eng_start_d  = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    data_d       = eng_result;
                    err_d        = 1'b0;
                    rsp0_valid_d = !owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = S_RESP;
                end else if (timeout_c) begin
                    data_d       = '0;
                    err_d        = 1'b1;
                    rsp0_valid_d = !owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_hs_c) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            base_q       <= '0;
            exp_q        <= '0;
            mod_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            eng_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            base_q       <= base_d;
            exp_q        <= exp_d;
            mod_q        <= mod_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            eng_start_q  <= eng_start_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = data_q;
    assign rsp1_data  = data_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    assign eng_start  = eng_start_q;
    assign eng_base   = base_q;
    assign eng_exp    = exp_q;
    assign eng_mod    = mod_q;
    assign busy       = (state_q != S_IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Bench for rsa_engine_arbiter: reactive engine stub, job-level reference model with a
// per-cycle compare, and directed scenarios with hand-computed latencies and results.
module tb_rsa_engine_arbiter;

    localparam int unsigned KW = 64;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [KW-1:0] req0_base = '0, req0_exp = '0, req0_mod = '0;
    logic [KW-1:0] req1_base = '0, req1_exp = '0, req1_mod = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [KW-1:0] rsp0_data, rsp1_data;
    logic          rsp0_err, rsp1_err;
    logic          eng_start, eng_abort, busy, owner;
    logic [KW-1:0] eng_base, eng_exp, eng_mod;
    logic          eng_done = 1'b0;
    logic [KW-1:0] eng_result = '0;

    rsa_engine_arbiter #(.KEY_WIDTH(KW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_base(req0_base), .req0_exp(req0_exp), .req0_mod(req0_mod),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_base(req1_base), .req1_exp(req1_exp), .req1_mod(req1_mod),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
        .eng_done(eng_done), .eng_result(eng_result), .eng_abort(eng_abort),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int n_abort  = 0;

    task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [KW-1:0] modexp(input logic [KW-1:0] b, input logic [KW-1:0] e,
                                             input logic [KW-1:0] m);
        logic [2*KW-1:0] r, x, mm;
        if (m == '0) return '0;
        mm = (2*KW)'(m);
        r  = (2*KW)'(1) % mm;
        x  = (2*KW)'(b) % mm;
        for (int i = 0; i < int'(KW); i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[KW-1:0];
    endfunction

    // Engine stub: answers with the true modexp result eng_lat cycles after eng_start.
    int            eng_lat = 3;
    int            eng_cnt = 0;
    logic [KW-1:0] eng_res = '0;
    bit            stray_done = 1'b0;

    always @(negedge clk) begin
        if (rst_n && eng_start === 1'b1) begin
            eng_cnt = eng_lat;
            eng_res = modexp(eng_base, eng_exp, eng_mod);
        end
    end

    always @(posedge clk) begin
        #1;
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = eng_res;
            end
        end
        if (stray_done) begin
            stray_done = 1'b0;
            eng_done   = 1'b1;
            eng_result = 64'hdead_beef;
        end
    end

    // Reference model: a job is tracked by its age in cycles since acceptance.
    bit            m_job = 1'b0, m_rsp = 1'b0, m_last = 1'b1, m_owner = 1'b0, m_err = 1'b0;
    int            m_age = 0;
    logic [KW-1:0] m_base = '0, m_exp = '0, m_mod = '0, m_data = '0;
    logic [KW-1:0] exp_q0[$];
    logic [KW-1:0] exp_q1[$];

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        return (v0 && v1) ? !last : v1;
    endfunction

    always @(posedge clk) begin : model
        bit w;
        cyc++;
        if (!rst_n) begin
            m_job = 0; m_rsp = 0; m_last = 1; m_owner = 0; m_err = 0; m_age = 0;
            m_base = '0; m_exp = '0; m_mod = '0; m_data = '0;
            exp_q0.delete();
            exp_q1.delete();
        end else if (!m_job) begin
            if (req0_valid || req1_valid) begin
                w = pick(req0_valid, req1_valid, m_last);
                m_job = 1; m_age = 0; m_owner = w; m_last = w;
                m_base = w ? req1_base : req0_base;
                m_exp  = w ? req1_exp  : req0_exp;
                m_mod  = w ? req1_mod  : req0_mod;
                if (w) exp_q1.push_back(modexp(m_base, m_exp, m_mod));
                else   exp_q0.push_back(modexp(m_base, m_exp, m_mod));
            end
        end else if (m_rsp) begin
            if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_job = 0; m_rsp = 0;
                if (m_owner) void'(exp_q1.pop_front());
                else         void'(exp_q0.pop_front());
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (eng_done) begin
            m_rsp = 1; m_data = eng_result; m_err = 0;
        end else if (m_age == int'(TO)) begin
            m_rsp = 1; m_data = '0; m_err = 1;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin : compare
        bit w, er0, er1;
        logic [KW-1:0] want;
        if (chk_en) begin
            w   = pick(req0_valid, req1_valid, m_last);
            er0 = rst_n && !m_job && req0_valid && !w;
            er1 = rst_n && !m_job && req1_valid && w;
            chk("req0_ready", 64'(req0_ready), 64'(er0));
            chk("req1_ready", 64'(req1_ready), 64'(er1));
            chk("busy", 64'(busy), 64'(m_job));
            chk("owner", 64'(owner), 64'(m_owner));
            chk("eng_start", 64'(eng_start), 64'(m_job && !m_rsp && m_age == 0));
            chk("eng_abort", 64'(eng_abort),
                64'(rst_n && m_job && !m_rsp && m_age == int'(TO) && !eng_done));
            chk("rsp0_valid", 64'(rsp0_valid), 64'(m_rsp && !m_owner));
            chk("rsp1_valid", 64'(rsp1_valid), 64'(m_rsp && m_owner));
            chk("rsp0_data", rsp0_data, m_data);
            chk("rsp1_data", rsp1_data, m_data);
            chk("rsp0_err", 64'(rsp0_err), 64'(m_err));
            chk("rsp1_err", 64'(rsp1_err), 64'(m_err));
            chk("eng_base", eng_base, m_base);
            chk("eng_exp", eng_exp, m_exp);
            chk("eng_mod", eng_mod, m_mod);
            if (eng_abort === 1'b1) n_abort++;
            // Delivered value must be the next result owed to that requester.
            if (rsp0_valid === 1'b1 && rsp0_ready) begin
                want = (exp_q0.size() > 0) ? exp_q0[0] : 64'hffff_ffff_ffff_ffff;
                chk("rsp0_order", rsp0_data, m_err ? '0 : want);
            end
            if (rsp1_valid === 1'b1 && rsp1_ready) begin
                want = (exp_q1.size() > 0) ? exp_q1[0] : 64'hffff_ffff_ffff_ffff;
                chk("rsp1_order", rsp1_data, m_err ? '0 : want);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit n, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((n ? req1_ready : req0_ready) === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("ready_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_any_ready(output int who);
        who = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                chk("grant_exclusive", 64'(req0_ready && req1_ready), 64'd0);
                who = (req1_ready === 1'b1) ? 1 : 0;
                break;
            end
        end
        if (who < 0) chk("grant_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input bit n, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((n ? rsp1_valid : rsp0_valid) === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("rsp_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("idle_wait_expired", 64'd0, 64'd1);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tr, ta, who, a0;
        logic [KW-1:0] held;

        chk("model_pin_4_13_497", modexp(64'd4, 64'd13, 64'd497), 64'd445);
        chk("model_pin_3_7_100", modexp(64'd3, 64'd7, 64'd100), 64'd87);

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_owner", 64'(owner), 64'd0);
        chk("reset_rsp0_data", rsp0_data, 64'd0);
        tick();

        // Single request: done 5 cycles after start, response 7 cycles after acceptance.
        eng_lat = 5;
        req0_base = 64'd4; req0_exp = 64'd13; req0_mod = 64'd497; req0_valid = 1'b1;
        wait_ready(1'b0, t);
        tick();
        req0_valid = 1'b0;
        wait_rsp(1'b0, tr);
        chk("single_latency", 64'(tr - t), 64'd7);
        chk("single_data", rsp0_data, 64'd445);
        chk("single_err", 64'(rsp0_err), 64'd0);
        tick();

        // Simultaneous requests after reset: 0 first, then strict alternation.
        do_reset();
        eng_lat = 2;
        req0_base = 64'd5; req0_exp = 64'd3; req0_mod = 64'd13;
        req1_base = 64'd6; req1_exp = 64'd2; req1_mod = 64'd7;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_any_ready(who);
            chk("rr_grant", 64'(who), 64'(g % 2));
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Timeout: engine silent, abort on the 8th wait cycle, error response.
        eng_lat = 0;
        a0 = n_abort;
        req1_base = 64'd9; req1_exp = 64'd9; req1_mod = 64'd11; req1_valid = 1'b1;
        wait_ready(1'b1, t);
        tick();
        req1_valid = 1'b0;
        ta = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eng_abort === 1'b1) begin
                ta = cyc;
                break;
            end
        end
        chk("timeout_abort_cycle", 64'(ta - t), 64'd9);
        wait_rsp(1'b1, tr);
        chk("timeout_rsp_cycle", 64'(tr - t), 64'd10);
        chk("timeout_data", rsp1_data, 64'd0);
        chk("timeout_err", 64'(rsp1_err), 64'd1);
        tick();
        chk("timeout_abort_count", 64'(n_abort - a0), 64'd1);

        eng_lat = 3;
        req0_base = 64'd7; req0_exp = 64'd5; req0_mod = 64'd33; req0_valid = 1'b1;
        wait_ready(1'b0, t);
        tick();
        req0_valid = 1'b0;
        wait_rsp(1'b0, tr);
        chk("after_timeout_latency", 64'(tr - t), 64'd5);
        chk("after_timeout_data", rsp0_data, 64'd10);
        chk("after_timeout_err", 64'(rsp0_err), 64'd0);
        tick();

        // Response backpressure on requester 1 while requester 0 waits.
        eng_lat = 2;
        rsp1_ready = 1'b0;
        req1_base = 64'd3; req1_exp = 64'd7; req1_mod = 64'd100; req1_valid = 1'b1;
        wait_ready(1'b1, t);
        tick();
        req1_valid = 1'b0;
        req0_base = 64'd2; req0_exp = 64'd5; req0_mod = 64'd7; req0_valid = 1'b1;
        wait_rsp(1'b1, tr);
        held = rsp1_data;
        chk("bp_data", held, 64'd87);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_hold", 64'(rsp1_valid), 64'd1);
            chk("bp_data_hold", rsp1_data, 64'd87);
            chk("bp_req0_blocked", 64'(req0_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp1_ready = 1'b1;
        wait_ready(1'b0, ta);
        chk("bp_req0_after", 64'(ta > tr), 64'd1);
        tick();
        req0_valid = 1'b0;
        wait_rsp(1'b0, tr);
        chk("bp_req0_data", rsp0_data, 64'd4);
        tick();

        // Stray done while idle is ignored.
        stray_done = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("stray_data_kept", rsp0_data, 64'd4);
        tick();

        // Reset in WAIT drops the job with no abort; a late done is ignored.
        eng_lat = 6;
        a0 = n_abort;
        req0_base = 64'd1; req0_exp = 64'd1; req0_mod = 64'd5; req0_valid = 1'b1;
        wait_ready(1'b0, t);
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_owner", 64'(owner), 64'd0);
        chk("rst_mid_eng_base", eng_base, 64'd0);
        chk("rst_mid_eng_mod", eng_mod, 64'd0);
        chk("rst_mid_data", rsp0_data, 64'd0);
        chk("rst_mid_err", 64'(rsp0_err), 64'd0);
        repeat (8) tick();
        chk("rst_mid_no_abort", 64'(n_abort - a0), 64'd0);
        chk("rst_mid_still_idle", 64'(busy), 64'd0);
        eng_lat = 2;
        req0_base = 64'd8; req0_exp = 64'd2; req0_mod = 64'd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_any_ready(who);
        chk("rst_mid_next_grant", 64'(who), 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Done on the last budget cycle counts as completion.
        eng_lat = 8;
        a0 = n_abort;
        req1_base = 64'd2; req1_exp = 64'd10; req1_mod = 64'd1000; req1_valid = 1'b1;
        wait_ready(1'b1, t);
        tick();
        req1_valid = 1'b0;
        wait_rsp(1'b1, tr);
        chk("edge_latency", 64'(tr - t), 64'd10);
        chk("edge_data", rsp1_data, 64'd24);
        chk("edge_err", 64'(rsp1_err), 64'd0);
        tick();
        chk("edge_no_abort", 64'(n_abort - a0), 64'd0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
